demultiplex: RTL and testbench

- Inverse of the stream multiplexer: accepts one tagged valid/ready stream of {tag, data} words and steers each data word to one of N output streams selected by the tag.
- Sits downstream of a multiplex link: fan-in → shared path → demultiplex → per-lane consumers.
- Registered input buffer (s_ready is a flop) plus one output register per lane; full throughput when lanes are ready.

---
 rtl/demultiplex.sv | 117 +++++++++++
 tb/tb_demultiplex.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/demultiplex.sv
// Tagged-stream demultiplexer: a 2-entry input buffer feeds N lane registers,
// steering each word to the lane selected by its tag; unknown tags are dropped with err.
module demultiplex #(
    parameter int W = 16,
    parameter int N = 4,
    localparam int T = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W+T-1:0]   s_data,
    output logic [N-1:0]     m_valid,
    input  logic [N-1:0]     m_ready,
    output logic [N*W-1:0]   m_data,
    output logic             err
);

    logic [W+T-1:0] head_q, head_d;
    logic [W+T-1:0] skid_q, skid_d;
    logic [1:0]     cnt_q, cnt_d;
    logic           s_ready_q, s_ready_d;
    logic [N-1:0]   m_valid_q, m_valid_d;
    logic [N*W-1:0] m_data_q, m_data_d;
    logic           err_q, err_d;

    logic [T-1:0]   head_tag;
    logic [W-1:0]   head_dat;
    logic           bad_tag;
    logic           lane_free;
    logic           route;
    logic           pop;
    logic           push;

    // Routing decision on the head of the input buffer
    always_comb begin
        head_tag  = head_q[W+T-1:W];
        head_dat  = head_q[W-1:0];
        bad_tag   = (int'(head_tag) >= N);
        lane_free = !bad_tag && (!m_valid_q[head_tag] || m_ready[head_tag]);
        route     = (cnt_q != 2'd0) && lane_free;
        pop       = (cnt_q != 2'd0) && (bad_tag || lane_free);
        push      = s_valid && s_ready_q;
    end

    // Input buffer: head is the oldest word, skid catches the word that arrives
    // while the head is stalled.
    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        cnt_d  = cnt_q;
        case (cnt_q)
            2'd0: begin
                if (push) begin
                    head_d = s_data;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = s_data;
                end else if (pop) begin
                    cnt_d = 2'd0;
                end else if (push) begin
                    skid_d = s_data;
                    cnt_d  = 2'd2;
                end
            end
            default: begin
                if (pop) begin
                    head_d = skid_q;
                    cnt_d  = 2'd1;
                end
            end
        endcase
        s_ready_d = (cnt_d != 2'd2);
        err_d     = pop && bad_tag;
    end

    // Lane registers: drain on accept, reload only the lane the head selects
    always_comb begin
        m_valid_d = m_valid_q & ~m_ready;
        m_data_d  = m_data_q;
        for (int i = 0; i < N; i++) begin
            if (route && (head_tag == T'(i))) begin
                m_valid_d[i]          = 1'b1;
                m_data_d[i*W +: W]    = head_dat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q    <= '0;
            skid_q    <= '0;
            cnt_q     <= 2'd0;
            s_ready_q <= 1'b0;
            m_valid_q <= '0;
            m_data_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            head_q    <= head_d;
            skid_q    <= skid_d;
            cnt_q     <= cnt_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            err_q     <= err_d;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign err     = err_q;

endmodule

// File: tb/tb_demultiplex.sv
// Directed bench for demultiplex: a 4-lane instance for routing/backpressure and
// a 3-lane instance for the discarded-tag path.
module tb_demultiplex;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [17:0] s_data = '0;
    logic [3:0]  m_valid;
    logic [3:0]  m_ready = 4'hF;
    logic [63:0] m_data;
    logic        err;

    logic        b_s_valid = 1'b0;
    logic        b_s_ready;
    logic [17:0] b_s_data = '0;
    logic [2:0]  b_m_valid;
    logic [2:0]  b_m_ready = 3'b111;
    logic [47:0] b_m_data;
    logic        b_err;

    int n_chk = 0;
    int n_err = 0;

    logic [17:0] pend_q[$];
    logic [17:0] exp_q[$];

    demultiplex #(.W(16), .N(4)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .err(err)
    );

    demultiplex #(.W(16), .N(3)) dut3 (
        .clk(clk), .rst(rst),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
        .err(b_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A lane delivered a word: it must be the oldest outstanding word for that lane.
    task automatic deliver(input int lane, input logic [15:0] d);
        int k;
        k = -1;
        for (int j = 0; j < exp_q.size(); j++) begin
            if (k < 0 && int'(exp_q[j][17:16]) == lane) k = j;
        end
        if (k < 0) begin
            chk($sformatf("rx_unexpected_lane%0d", lane), {48'h0, d}, 64'hFFFF_FFFF);
        end else begin
            chk($sformatf("rx_lane%0d", lane), {48'h0, d}, {48'h0, exp_q[k][15:0]});
            exp_q.delete(k);
        end
    endtask

    // One negedge-aligned cycle per iteration: offer the pending word, pick m_ready,
    // book every handshake that the coming posedge will complete.
    task automatic run(input int cycles, input bit until_done, input logic [3:0] mask, input bit rnd);
        int  c;
        bit  done;
        c    = 0;
        done = 1'b0;
        while (!done) begin
            s_valid = (pend_q.size() > 0);
            s_data  = s_valid ? pend_q[0] : 18'h0;
            m_ready = rnd ? 4'($urandom_range(0, 15)) : mask;
            for (int i = 0; i < 4; i++) begin
                if (m_valid[i] && m_ready[i]) deliver(i, m_data[i*16 +: 16]);
            end
            if (s_valid && s_ready) begin
                exp_q.push_back(pend_q[0]);
                pend_q.delete(0);
            end
            @(posedge clk);
            @(negedge clk);
            c++;
            if (until_done && pend_q.size() == 0 && exp_q.size() == 0 && m_valid == 4'h0) done = 1'b1;
            if (!done && c >= cycles) begin
                if (until_done) chk("run_timeout", 64'(pend_q.size() + exp_q.size()), 64'h0);
                done = 1'b1;
            end
        end
        s_valid = 1'b0;
    endtask

    initial begin
        logic [1:0]  t2;
        logic [3:0]  exp_v;

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        chk("rst_m_valid", 64'(m_valid), 64'h0);
        chk("rst_s_ready", 64'(s_ready), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_b_m_valid", 64'(b_m_valid), 64'h0);
        chk("rst_m_data", m_data, 64'h0);
        rst = 1'b0;
        #1;
        chk("rel_s_ready_before_edge", 64'(s_ready), 64'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rel_s_ready", 64'(s_ready), 64'h1);

        // Single word to lane 2
        s_valid = 1'b1;
        s_data  = {2'd2, 16'hBEEF};
        m_ready = 4'hF;
        chk("single_s_ready", 64'(s_ready), 64'h1);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        chk("single_lat1", 64'(m_valid), 64'h0);
        @(posedge clk);
        @(negedge clk);
        chk("single_m_valid", 64'(m_valid), 64'h4);
        chk("single_data", 64'(m_data[32 +: 16]), 64'hBEEF);
        @(posedge clk);
        @(negedge clk);
        chk("single_drained", 64'(m_valid), 64'h0);

        // Back-to-back streaming over all lanes
        for (int cyc = 0; cyc < 7; cyc++) begin
            t2      = 2'(cyc);
            s_valid = (cyc < 4);
            s_data  = {t2, 16'(16'hA000 + cyc)};
            m_ready = 4'hF;
            if (cyc < 4) chk($sformatf("stream_s_ready%0d", cyc), 64'(s_ready), 64'h1);
            exp_v = (cyc >= 2 && cyc < 6) ? 4'(1 << (cyc - 2)) : 4'h0;
            chk($sformatf("stream_m_valid%0d", cyc), 64'(m_valid), 64'(exp_v));
            if (cyc >= 2 && cyc < 6)
                chk($sformatf("stream_data%0d", cyc), 64'(m_data[(cyc-2)*16 +: 16]), 64'(16'hA000 + cyc - 2));
            @(posedge clk);
            @(negedge clk);
        end
        s_valid = 1'b0;

        // Head-of-line blocking behind a stalled lane 1
        pend_q.push_back({2'd1, 16'h1111});
        pend_q.push_back({2'd1, 16'h2222});
        pend_q.push_back({2'd3, 16'h3333});
        pend_q.push_back({2'd0, 16'h4444});
        run(5, 1'b0, 4'b1101, 1'b0);
        chk("hol_s_ready", 64'(s_ready), 64'h0);
        chk("hol_m_valid", 64'(m_valid), 64'h2);
        chk("hol_lane1", 64'(m_data[16 +: 16]), 64'h1111);
        chk("hol_pending", 64'(pend_q.size()), 64'h1);
        run(40, 1'b1, 4'hF, 1'b0);
        chk("hol_s_ready_after", 64'(s_ready), 64'h1);

        // Random tags/data with random per-lane backpressure
        for (int i = 0; i < 8; i++) begin
            t2 = 2'($urandom_range(0, 3));
            pend_q.push_back({t2, 16'($urandom)});
        end
        run(300, 1'b1, 4'hF, 1'b1);
        m_ready = 4'hF;

        // Discarded tag on the 3-lane instance
        b_s_valid = 1'b1;
        b_s_data  = {2'd3, 16'hDEAD};
        chk("bad_s_ready", 64'(b_s_ready), 64'h1);
        @(posedge clk);
        @(negedge clk);
        b_s_data = {2'd0, 16'h1234};
        chk("bad_err_early", 64'(b_err), 64'h0);
        @(posedge clk);
        @(negedge clk);
        b_s_valid = 1'b0;
        chk("bad_err_pulse", 64'(b_err), 64'h1);
        chk("bad_no_valid", 64'(b_m_valid), 64'h0);
        @(posedge clk);
        @(negedge clk);
        chk("bad_err_clear", 64'(b_err), 64'h0);
        chk("bad_lane0_valid", 64'(b_m_valid), 64'h1);
        chk("bad_lane0_data", 64'(b_m_data[15:0]), 64'h1234);
        @(posedge clk);
        @(negedge clk);
        chk("bad_drained", 64'(b_m_valid), 64'h0);

        // Reset asserted with words in both stages
        pend_q.push_back({2'd0, 16'h5555});
        pend_q.push_back({2'd1, 16'h6666});
        pend_q.push_back({2'd0, 16'h7777});
        run(3, 1'b0, 4'h0, 1'b0);
        chk("mid_loaded", 64'(m_valid), 64'h3);
        exp_q.delete();
        pend_q.delete();
        #2 rst = 1'b1;
        #1;
        chk("mid_async_m_valid", 64'(m_valid), 64'h0);
        chk("mid_async_s_ready", 64'(s_ready), 64'h0);
        chk("mid_async_data", m_data, 64'h0);
        @(negedge clk);
        rst     = 1'b0;
        m_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("mid_no_stale%0d", i), 64'(m_valid), 64'h0);
        end
        chk("mid_s_ready", 64'(s_ready), 64'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
